dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the memory execution stage.
- Accepts one load/store request (r_v/w_v, address, data, byte strobe) and drives a word-addressed request/grant/response data bus.
- Returns a one-cycle hit pulse with right-aligned load data to the memory stage.
- Holds at most one request outstanding; a busy flag tells the memory stage when to hold off.

Parameters:
- xlen, 32, address and data width
- TIMEOUT, 64, cycles to wait for bus_rvalid before aborting; used only with DMEM_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r_v  in  1  load request strobe from the memory stage
- w_v  in  1  store request strobe from the memory stage
- req_adr  in  xlen  byte address
- req_data  in  xlen  store data, unshifted (byte 0 = bits 7:0)
- req_strobe  in  4  byte-lane enables, already positioned by address offset
- busy  out  1  controller holds a request; new r_v/w_v ignored
- hit  out  1  one-cycle completion pulse
- mem_res  out  xlen  load data, right-shifted by address byte offset
- err  out  1  one-cycle pulse with hit on a timeout abort (tied 0 without the macro)
- bus_req  out  1  bus request valid
- bus_we  out  1  1 = write
- bus_adr  out  xlen  word address, req_adr with bits 1:0 forced to 0
- bus_wdata  out  xlen  write data shifted into lanes by 8*req_adr[1:0]
- bus_be  out  4  byte enables, copied from req_strobe
- bus_gnt  in  1  bus accepted the request this cycle
- bus_rvalid  in  1  response valid; for both read and write
- bus_rdata  in  xlen  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - busy, hit, err, bus_req, bus_we = 0.
  - bus_adr, bus_wdata, bus_be, mem_res = 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On r_v or w_v, register address, shifted data, strobe, we = w_v and offset = req_adr[1:0].
  - Go to REQ; busy=1 from the next cycle.
  - If r_v and w_v are both high, treat as a load (we=0).
- REQ:
  - bus_req=1; address, data, be and we stay stable until grant.
  - On bus_gnt: bus_req=0 next cycle, go to WAIT.
  - If bus_gnt and bus_rvalid are both high in the same cycle, go straight to RESP and capture data.
- WAIT:
  - On bus_rvalid, capture bus_rdata >> (8*offset), zero-filled, into mem_res and go to RESP.
  - For writes the captured data is don't-care; mem_res is held at its previous value.
- RESP:
  - hit=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
  - Minimum latency from r_v to hit: 3 cycles (IDLE→REQ→RESP with same-cycle gnt+rvalid).
- mem_res holds its value until the next load completes. Sign/zero extension is the consumer's job.
- r_v/w_v while busy=1 are dropped, not queued.
- bus_rvalid outside WAIT (or REQ with gnt) is ignored.
- Reset asserted mid-transaction returns to IDLE immediately; the outstanding bus response is discarded.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT, go to RESP with hit=1, err=1, mem_res=0; bus_req drops.
  - A late bus_rvalid is then ignored in IDLE.
- Undefined: no counter; the controller waits indefinitely; err tied 0.

Test Plan:
- Load word: r_v, req_adr=0x100; gnt on cycle 2, rvalid+rdata=0xDEADBEEF two cycles later → bus_adr=0x100, bus_we=0, one hit, mem_res=0xDEADBEEF.
- Load byte at offset 3: req_adr=0x203, strobe=1000, rdata=0xAB123456 → bus_adr=0x200, bus_be=1000, mem_res=0x000000AB.
- Store half: w_v, req_adr=0x302, req_data=0x0000BEEF, strobe=1100 → bus_we=1, bus_wdata=0xBEEF0000, bus_be=1100; hit on rvalid; mem_res unchanged.
- Back-pressure: bus_gnt low 5 cycles → bus_req and bus fields stable for all 5 cycles; a second r_v during busy is dropped (exactly one bus_req transaction).
- Same-cycle gnt+rvalid with rdata=0x11 → hit 3 cycles after r_v, mem_res=0x11; async rst_n pulse in WAIT → all outputs 0, no hit on the later rvalid.
- With DMEM_TIMEOUT_EN, TIMEOUT=8, no rvalid → hit=err=1 eight cycles after entering REQ, mem_res=0; a late rvalid is ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller between the memory
// stage and a word-addressed request/grant/response data bus.
// Optional build macro: DMEM_TIMEOUT_EN enables the response timeout abort.
module dmem_ctrl #(
    parameter int unsigned xlen    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [xlen-1:0] req_adr,
    input  logic [xlen-1:0] req_data,
    input  logic [3:0]      req_strobe,
    output logic            busy,
    output logic            hit,
    output logic [xlen-1:0] mem_res,
    output logic            err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [xlen-1:0] bus_adr,
    output logic [xlen-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [xlen-1:0] bus_rdata
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    typedef logic [TO_W-1:0] to_cnt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_capture;
    logic            w_timeout;

    logic            r_busy;
    logic            r_hit;
    logic            r_req;
    logic            r_we;
    logic [1:0]      r_off;
    logic [xlen-1:0] r_adr;
    logic [xlen-1:0] r_wdata;
    logic [3:0]      r_be;
    logic [xlen-1:0] r_mem_res;

`ifdef DMEM_TIMEOUT_EN
    to_cnt_t         r_cnt;
    logic            r_err;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and transaction event decode
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_v || w_v) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    if (bus_rvalid) begin
                        w_capture = 1'b1;
                        w_next    = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
`ifdef DMEM_TIMEOUT_EN
        // A response arriving in the final cycle still wins over the abort
        if ((r_state == S_REQ || r_state == S_WAIT) && !w_capture &&
            (r_cnt == to_cnt_t'(TIMEOUT - 1))) begin
            w_timeout = 1'b1;
            w_next    = S_RESP;
        end
`endif
    end

`ifdef DMEM_TIMEOUT_EN
    // Cycles spent in REQ/WAIT since the request was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == S_REQ || r_state == S_WAIT) begin
                r_cnt <= r_cnt + to_cnt_t'(1);
            end
        end
    end
`endif

    // Registered outputs, request capture and load data alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_hit     <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_off     <= 2'd0;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_be      <= 4'd0;
            r_mem_res <= '0;
        end else begin
            r_busy <= (w_next == S_REQ) || (w_next == S_WAIT);
            r_hit  <= (w_next == S_RESP);
            r_req  <= (w_next == S_REQ);
            if (w_accept) begin
                r_adr   <= {req_adr[xlen-1:2], 2'b00};
                r_wdata <= req_data << {req_adr[1:0], 3'b000};
                r_be    <= req_strobe;
                r_we    <= w_v && !r_v;
                r_off   <= req_adr[1:0];
            end
            if (w_capture && !r_we) begin
                r_mem_res <= bus_rdata >> {r_off, 3'b000};
            end else if (w_timeout) begin
                r_mem_res <= '0;
            end
        end
    end

    assign busy      = r_busy;
    assign hit       = r_hit;
    assign mem_res   = r_mem_res;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_adr   = r_adr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;

`ifdef DMEM_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 64;
`endif

    logic        clk;
    logic        rst_n;
    logic        r_v;
    logic        w_v;
    logic [31:0] req_adr;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic        busy;
    logic        hit;
    logic [31:0] mem_res;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;
    int txn0;

    dmem_ctrl #(.xlen(32), .TIMEOUT(TO)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r_v        (r_v),
        .w_v        (w_v),
        .req_adr    (req_adr),
        .req_data   (req_data),
        .req_strobe (req_strobe),
        .busy       (busy),
        .hit        (hit),
        .mem_res    (mem_res),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_adr    (bus_adr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus requests
    always @(posedge clk) begin
        if (rst_n && bus_req && bus_gnt) n_txn <= n_txn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns in the first REQ cycle
    task automatic start_req(input logic rv, input logic wv, input logic [31:0] adr,
                             input logic [31:0] data, input logic [3:0] strb);
        r_v = rv; w_v = wv; req_adr = adr; req_data = data; req_strobe = strb;
        @(negedge clk);
        r_v = 1'b0; w_v = 1'b0;
    endtask

    // Grant now, respond after gap WAIT cycles; returns in the RESP cycle
    task automatic grant_resp(input int gap, input logic [31:0] rdata);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        repeat (gap) @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = rdata;
        @(negedge clk);
        bus_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; r_v = 1'b0; w_v = 1'b0; req_adr = '0; req_data = '0;
        req_strobe = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_adr", bus_adr, 32'd0);
        chk("rst_memres", mem_res, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load word
        start_req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("lw_req", 32'(bus_req), 32'd1);
        chk("lw_busy", 32'(busy), 32'd1);
        chk("lw_adr", bus_adr, 32'h100);
        chk("lw_we", 32'(bus_we), 32'd0);
        grant_resp(1, 32'hDEADBEEF);
        chk("lw_hit", 32'(hit), 32'd1);
        chk("lw_busy_resp", 32'(busy), 32'd0);
        chk("lw_err", 32'(err), 32'd0);
        chk("lw_memres", mem_res, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_hit_once", 32'(hit), 32'd0);

        // Load byte at offset 3
        start_req(1'b1, 1'b0, 32'h203, 32'h0, 4'b1000);
        chk("lb_adr", bus_adr, 32'h200);
        chk("lb_be", 32'(bus_be), 32'h8);
        grant_resp(0, 32'hAB123456);
        chk("lb_hit", 32'(hit), 32'd1);
        chk("lb_memres", mem_res, 32'h000000AB);
        @(negedge clk);

        // Store half at offset 2
        start_req(1'b0, 1'b1, 32'h302, 32'h0000BEEF, 4'b1100);
        chk("sh_we", 32'(bus_we), 32'd1);
        chk("sh_adr", bus_adr, 32'h300);
        chk("sh_wdata", bus_wdata, 32'hBEEF0000);
        chk("sh_be", 32'(bus_be), 32'hC);
        grant_resp(1, 32'hFFFFFFFF);
        chk("sh_hit", 32'(hit), 32'd1);
        chk("sh_memres_held", mem_res, 32'h000000AB);
        @(negedge clk);

        // Back-pressure with a dropped second request
        txn0 = n_txn;
        start_req(1'b1, 1'b1, 32'h404, 32'h12345678, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req", 32'(bus_req), 32'd1);
            chk("bp_adr", bus_adr, 32'h404);
            chk("bp_we_both", 32'(bus_we), 32'd0);
            if (i == 2) begin
                r_v = 1'b1; req_adr = 32'h500;
            end
            @(negedge clk);
            r_v = 1'b0;
        end
        grant_resp(0, 32'h55667788);
        chk("bp_hit", 32'(hit), 32'd1);
        chk("bp_memres", mem_res, 32'h55667788);
        repeat (2) @(negedge clk);
        chk("bp_idle_req", 32'(bus_req), 32'd0);
        chk("bp_one_txn", 32'(n_txn - txn0), 32'd1);

        // Same-cycle grant and response: hit in the third cycle
        start_req(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        chk("fast_nohit", 32'(hit), 32'd0);
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h11;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("fast_hit", 32'(hit), 32'd1);
        chk("fast_memres", mem_res, 32'h11);
        @(negedge clk);

        // Async reset while waiting for a response
        start_req(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rw_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_busy0", 32'(busy), 32'd0);
        chk("rw_adr0", bus_adr, 32'd0);
        chk("rw_memres0", mem_res, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h99;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("rw_nohit", 32'(hit), 32'd0);
        @(negedge clk);
        chk("rw_nohit2", 32'(hit), 32'd0);
        chk("rw_memres", mem_res, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // Timeout abort with a late response ignored
        start_req(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
        repeat (7) begin
            chk("to_nohit", 32'(hit), 32'd0);
            @(negedge clk);
        end
        chk("to_last_nohit", 32'(hit), 32'd0);
        @(negedge clk);
        chk("to_hit", 32'(hit), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_memres", mem_res, 32'd0);
        chk("to_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("to_late_hit", 32'(hit), 32'd0);
        chk("to_late_busy", 32'(busy), 32'd0);
`else
        // Without the timeout the controller keeps waiting
        start_req(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
        repeat (20) @(negedge clk);
        chk("nt_busy", 32'(busy), 32'd1);
        chk("nt_nohit", 32'(hit), 32'd0);
        grant_resp(0, 32'hCAFEF00D);
        chk("nt_hit", 32'(hit), 32'd1);
        chk("nt_err", 32'(err), 32'd0);
        chk("nt_memres", mem_res, 32'hCAFEF00D);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
